// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and default width shared by the serial adder
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t RUN  = 2'b01;
    localparam state_t DONE = 2'b10;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: one-bit full adder built from two half-adder stages
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    logic p, g1, g2;

    assign p     = a ^ b;
    assign g1    = a & b;
    assign sum   = p ^ c;
    assign g2    = p & c;
    assign carry = g1 | g2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first, one bit per cycle; SERIAL_ADDER_SUB_EN adds a sub port for a-b
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, b_load;
    logic [CW-1:0]    cnt;
    logic             carry, carry_load, cout_r, s_bit, c_bit, last;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub;
`else
    assign b_load     = b;
    assign carry_load = 1'b0;
`endif

    full_adder_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .c    (carry),
        .sum  (s_bit),
        .carry(c_bit)
    );

    assign last = cnt == CW'(WIDTH - 1);

    // FSM, operand capture and one-bit-per-cycle shift/accumulate
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                a_sh  <= a;
                b_sh  <= b_load;
                carry <= carry_load;
                cnt   <= '0;
                state <= RUN;
            end
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
            carry  <= c_bit;
            cnt    <= cnt + CW'(1);
            if (last) begin
                cout_r <= c_bit;
                state  <= DONE;
            end
        end else begin
            state <= IDLE;
        end
    end

    assign busy = state == RUN;
    assign done = state == DONE;
    assign sum  = sum_sh;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized and directed checks of serial_adder_ctrl at widths 8, 2 and 32
module tb_serial_adder_ctrl;
    localparam int WS [3] = '{8, 2, 32};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        start_v = '0;
    logic [2:0]        sub_v = '0;
    logic [2:0]        busy_v, done_v, cout_v;
    logic [2:0][31:0]  a_v = '0;
    logic [2:0][31:0]  b_v = '0;
    logic [2:0][31:0]  sum_v;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [WS[g]-1:0] s_w;
        serial_adder_ctrl #(.WIDTH(WS[g])) u_dut (
            .clk  (clk),
            .rst  (rst),
            .start(start_v[g]),
`ifdef SERIAL_ADDER_SUB_EN
            .sub  (sub_v[g]),
`endif
            .a    (a_v[g][WS[g]-1:0]),
            .b    (b_v[g][WS[g]-1:0]),
            .busy (busy_v[g]),
            .done (done_v[g]),
            .sum  (s_w),
            .cout (cout_v[g])
        );
        assign sum_v[g] = 32'(s_w);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference: arithmetic on wide integers, masked to the instance width
    function automatic logic [63:0] ref_full(input int w, input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [63:0] m;
        m = (64'd1 << w) - 1;
        return (64'(x) & m) + (s ? (~64'(y) & m) : (64'(y) & m)) + 64'(s);
    endfunction

    task automatic run_op(input int k, input logic [31:0] x, input logic [31:0] y, input logic s);
        int          w, busy_n, done_n, done_at;
        logic [63:0] m, full, got_sum, got_c;
        w = WS[k];
        m = (64'd1 << w) - 1;
        full = ref_full(w, x, y, s);
        busy_n = 0; done_n = 0; done_at = 0; got_sum = '0; got_c = '0;
        @(negedge clk);
        a_v[k] = x; b_v[k] = y; sub_v[k] = s; start_v[k] = 1'b1;
        for (int i = 1; i <= w + 1; i++) begin
            @(negedge clk);
            busy_n += int'(busy_v[k]);
            if (done_v[k]) begin
                done_n++;
                done_at = i;
                got_sum = 64'(sum_v[k]);
                got_c = 64'(cout_v[k]);
            end
            a_v[k] = $urandom;
            b_v[k] = $urandom;
            start_v[k] = (i <= w) ? 1'($urandom) : 1'b0;
        end
        check("busy_cycles", 64'(busy_n), 64'(w));
        check("done_count", 64'(done_n), 64'd1);
        check("latency", 64'(done_at), 64'(w + 1));
        check("sum", got_sum, full & m);
        check("cout", got_c, (full >> w) & 64'd1);
        @(negedge clk);
        check("sum_hold", 64'(sum_v[k]), full & m);
        check("idle_flags", {62'd0, busy_v[k], done_v[k]}, 64'd0);
    endtask

    initial begin
        int          dn, pos;
        logic [63:0] got;
        logic [31:0] r;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_busy", 64'(busy_v[k]), 64'd0);
            check("rst_done", 64'(done_v[k]), 64'd0);
            check("rst_sum", 64'(sum_v[k]), 64'd0);
            check("rst_cout", 64'(cout_v[k]), 64'd0);
        end
        rst = 1'b0;

        run_op(0, 32'h5A, 32'h3C, 1'b0);
        check("dir_5a_3c", 64'(sum_v[0]), 64'h96);
        run_op(0, 32'hFF, 32'h01, 1'b0);
        check("dir_ff_01", {31'd0, cout_v[0], sum_v[0]}, {32'd1, 32'h00});
        run_op(0, 32'hFF, 32'hFF, 1'b0);
        check("dir_ff_ff", {31'd0, cout_v[0], sum_v[0]}, {32'd1, 32'hFE});
`ifdef SERIAL_ADDER_SUB_EN
        run_op(0, 32'h10, 32'h20, 1'b1);
        check("sub_10_20", {31'd0, cout_v[0], sum_v[0]}, {32'd0, 32'hF0});
        run_op(0, 32'h20, 32'h10, 1'b1);
        check("sub_20_10", {31'd0, cout_v[0], sum_v[0]}, {32'd1, 32'h10});
`endif

        // start held high, a changed mid-run: one done per 10-cycle window
        r = $urandom;
        @(negedge clk);
        a_v[0] = 32'h11; b_v[0] = 32'h22; start_v[0] = 1'b1;
        for (int wi = 0; wi < 2; wi++) begin
            dn = 0; pos = 0; got = '0;
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                if (wi == 0 && n == 3) a_v[0] = r;
                if (done_v[0]) begin
                    dn++;
                    pos = n;
                    got = 64'(sum_v[0]);
                end
            end
            check("hold_done_count", 64'(dn), 64'd1);
            check("hold_done_pos", 64'(pos), 64'd9);
            check("hold_sum", got, wi == 0 ? 64'h33 : ref_full(8, r, 32'h22, 1'b0) & 64'hFF);
        end
        start_v[0] = 1'b0;
        @(negedge clk);

        // reset at RUN cycle 4 aborts with no done pulse
        a_v[0] = 32'h5A; b_v[0] = 32'h3C; start_v[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy_v[0]), 64'd0);
        check("abort_sum", 64'(sum_v[0]), 64'd0);
        check("abort_cout", 64'(cout_v[0]), 64'd0);
        rst = 1'b0;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            dn += int'(done_v[0]);
        end
        check("abort_no_done", 64'(dn), 64'd0);
        run_op(0, 32'h5A, 32'h3C, 1'b0);

        // reset and start on the same edge: start dropped
        @(negedge clk);
        rst = 1'b1; start_v[0] = 1'b1;
        @(negedge clk);
        check("rst_start_busy", 64'(busy_v[0]), 64'd0);
        rst = 1'b0; start_v[0] = 1'b0;
        @(negedge clk);
        check("rst_start_idle", 64'(busy_v[0]), 64'd0);

        for (int k = 0; k < 3; k++)
            for (int t = 0; t < 15; t++)
`ifdef SERIAL_ADDER_SUB_EN
                run_op(k, $urandom, $urandom, 1'($urandom));
`else
                run_op(k, $urandom, $urandom, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured on the accepted start cycle.
REQ-006 Port: b  input  WIDTH  operand B; captured on the accepted start cycle.
REQ-007 Port: busy  output  1  high while an operation is in progress (RUN state).
REQ-008 Port: done  output  1  one-cycle pulse when the result is valid.
REQ-009 Port: sum  output  WIDTH  result register; holds its value until the next accepted start.
REQ-010 Port: cout  output  1  final carry out; holds its value with sum.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 IDLE with start=1 SHALL capture a and b into shift registers, clear the carry flop, clear the bit counter, and go to RUN on the next edge.
REQ-013 In RUN, each cycle SHALL add one bit pair, LSB first, using a one-bit full adder with the stored carry.
REQ-014 Each RUN cycle SHALL shift the sum bit into the MSB of the sum shift register and update the carry flop.
REQ-015 RUN SHALL last exactly WIDTH cycles; the counter SHALL be $clog2(WIDTH)+1 bits wide and must not wrap early.
REQ-016 After the last RUN cycle the FSM SHALL go to DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, sum and cout SHALL be valid, and the FSM SHALL return to IDLE.
REQ-018 Latency SHALL be WIDTH+1 cycles from the accepted start edge to the done cycle. The earliest next accept is the cycle after DONE.
REQ-019 start SHALL be ignored in RUN and DONE: it is not queued and operands are not recaptured.
REQ-020 Changes on a or b after capture SHALL NOT affect the result.
REQ-021 The result SHALL be (a+b) mod 2^WIDTH, with cout equal to bit WIDTH of the full sum.
REQ-022 busy SHALL be 1 only in RUN. done SHALL be 1 only in DONE.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE and set busy=0, done=0, sum=0, cout=0, carry=0 and counter=0.
REQ-024 Reset SHALL override any state, including mid-RUN. The aborted operation SHALL produce no done pulse.
REQ-025 If rst and start are both 1 on the same edge, reset SHALL win and start SHALL be dropped.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN, when defined, SHALL add port sub (input, 1 bit), captured with the operands.
REQ-027 With sub=1, the block SHALL compute a-b as a+~b with carry initialised to 1. cout=1 means no borrow.
REQ-028 With SERIAL_ADDER_SUB_EN undefined, the sub port and its logic SHALL be absent, and carry SHALL always initialise to 0.

Structure
REQ-029 Package serial_adder_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-030 Sub-module full_adder_bit SHALL implement the one-bit sum/carry logic.
  - Built as two XOR/AND half-adder stages plus an OR for carry.
  - Instantiated once.
REQ-031 The FSM, counter and shift registers SHALL live in serial_adder_ctrl.

Verification
REQ-032 Addition: WIDTH=8, a=0x5A, b=0x3C, start one cycle -> busy high 8 cycles, done on cycle 9, sum=0x96, cout=0.
REQ-033 Carry and wrap: a=0xFF, b=0x01 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF -> sum=0xFE, cout=1.
REQ-034 Start during operation: start held high throughout, a changed mid-RUN -> exactly one done per 10-cycle window, result from the captured operands.
REQ-035 Reset mid-operation: rst at RUN cycle 4 -> next cycle IDLE, sum=0, no done pulse; then a new start completes correctly.
REQ-036 Subtraction (SERIAL_ADDER_SUB_EN): sub=1, a=0x10, b=0x20 -> sum=0xF0, cout=0. Also a=0x20, b=0x10 -> sum=0x10, cout=1.
REQ-037 Width sweep: WIDTH=2 and WIDTH=32, random operands against a reference model -> all results match, latency WIDTH+1.
